// File: rtl/wb_arbiter.sv
// Round-robin Wishbone B4 arbiter: N_MASTER masters share one slave-side port, grant held per CYC.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to enable the stalled-slave timeout and timeout_flag.
module wb_arbiter #(
  parameter int N_MASTER = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MASTER-1:0]        m_cyc,
  input  logic [N_MASTER-1:0]        m_stb,
  input  logic [N_MASTER-1:0]        m_we,
  input  logic [N_MASTER*ADDR_W-1:0] m_adr,
  input  logic [N_MASTER*DATA_W-1:0] m_dat_o,
  output logic [N_MASTER-1:0]        m_ack,
  output logic [DATA_W-1:0]          m_dat_i,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_adr,
  output logic [DATA_W-1:0]          s_dat_o,
  input  logic [DATA_W-1:0]          s_dat_i,
  input  logic                       s_ack,
  output logic [N_MASTER-1:0]        grant,
  output logic                       timeout_flag,
  output logic                       dbg_state
);

  // Handshake: a master owns the bus from its grant until it drops CYC; each
  // beat completes when STB is high and ACK returns in the same cycle.

  localparam int OW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  if (N_MASTER < 1 || N_MASTER > 8) begin : g_bad_n
    $error("wb_arbiter: N_MASTER must be 1..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter: TIMEOUT must be 1..65535");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state;
  logic [OW-1:0]         owner;
  logic [OW-1:0]         last;
  logic [OW-1:0]         next_owner;
  logic [OW-1:0]         cand;
  logic [N_MASTER-1:0]   next_grant;
  logic                  found;
  logic                  to_fire;

  assign dbg_state = state;

  // Scan from the slot after the previous owner so every requester gets a turn.
  always_comb begin
    found      = 1'b0;
    next_owner = '0;
    cand       = '0;
    for (int k = 1; k <= N_MASTER; k++) begin
      cand = OW'((int'(last) + k) % N_MASTER);
      if (!found && m_cyc[cand]) begin
        found      = 1'b1;
        next_owner = cand;
      end
    end
    next_grant             = '0;
    next_grant[next_owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(N_MASTER - 1);
      grant <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner <= next_owner;
            grant <= next_grant;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!m_cyc[owner]) begin
            last  <= owner;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] to_cnt;

  assign to_fire = (state == BUSY) && (to_cnt == CW'(TIMEOUT));

  // The count restarts after a forced ACK so a still-stalled slave trips again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == IDLE || s_ack || to_fire) begin
        to_cnt <= '0;
      end else if (m_stb[owner]) begin
        to_cnt <= to_cnt + CW'(1);
      end
      if (to_fire) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign to_fire      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    m_ack   = '0;
    m_dat_i = '0;
    if (state == BUSY) begin
      s_cyc        = m_cyc[owner];
      s_stb        = m_stb[owner] & ~to_fire;
      s_we         = m_we[owner];
      s_adr        = m_adr[int'(owner)*ADDR_W +: ADDR_W];
      s_dat_o      = m_dat_o[int'(owner)*DATA_W +: DATA_W];
      m_ack[owner] = s_ack | to_fire;
      m_dat_i      = to_fire ? '0 : s_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: vector table, hand-written corner sequences and a randomized
// run checked against a round-robin reference model (3 masters).
module tb_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
  logic [N*AW-1:0] m_adr = '0;
  logic [N*DW-1:0] m_dat_o = '0;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_dat_i;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_ack = 1'b0;
  logic [N-1:0]    grant;
  logic            timeout_flag;
  logic            dbg_state;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  wb_arbiter #(.N_MASTER(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_o(m_dat_o),
    .m_ack(m_ack), .m_dat_i(m_dat_i),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack),
    .grant(grant), .timeout_flag(timeout_flag), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: all driving happens at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_o = '0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] cyc;
    logic [N-1:0] stb;
    logic         ack;
    logic [N-1:0] exp_grant;
    logic         exp_scyc;
    logic         exp_sstb;
    logic [N-1:0] exp_mack;
  } vec_t;

  vec_t tbl[16];

  // reference model state: owner (-1 = bus free) and last owner
  int own;
  int lst;

  initial begin
    logic [N-1:0] req;
    logic [N-1:0] eg;
    int since_ack;
    int o;

    // reset values with every input active
    m_cyc = '1; m_stb = '1; m_we = '1; m_adr = '1; m_dat_o = '1;
    s_ack = 1'b1; s_dat_i = '1;
    @(negedge clk); #1;
    check("rst_grant", grant, 0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_stb", s_stb, 0);
    check("rst_s_we", s_we, 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_s_dat_o", s_dat_o, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_dat_i", m_dat_i, 0);
    check("rst_timeout_flag", timeout_flag, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;

    // vector table, applied one cycle per entry starting from reset
    tbl[0]  = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    tbl[1]  = '{3'b011, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    tbl[2]  = '{3'b011, 3'b011, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000};
    tbl[3]  = '{3'b011, 3'b011, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001};
    tbl[4]  = '{3'b010, 3'b010, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000};
    tbl[5]  = '{3'b010, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    tbl[6]  = '{3'b010, 3'b010, 1'b0, 3'b010, 1'b1, 1'b1, 3'b000};
    tbl[7]  = '{3'b010, 3'b010, 1'b1, 3'b010, 1'b1, 1'b1, 3'b010};
    tbl[8]  = '{3'b100, 3'b100, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000};
    tbl[9]  = '{3'b100, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    tbl[10] = '{3'b101, 3'b101, 1'b0, 3'b100, 1'b1, 1'b1, 3'b000};
    tbl[11] = '{3'b001, 3'b001, 1'b0, 3'b100, 1'b0, 1'b0, 3'b000};
    tbl[12] = '{3'b001, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    tbl[13] = '{3'b001, 3'b001, 1'b0, 3'b001, 1'b1, 1'b1, 3'b000};
    tbl[14] = '{3'b000, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 3'b000};
    tbl[15] = '{3'b000, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 3'b000};
    for (int v = 0; v < 16; v++) begin
      m_cyc = tbl[v].cyc; m_stb = tbl[v].stb; s_ack = tbl[v].ack;
      #1;
      check($sformatf("tbl%0d_grant", v), grant, tbl[v].exp_grant);
      check($sformatf("tbl%0d_s_cyc", v), s_cyc, tbl[v].exp_scyc);
      check($sformatf("tbl%0d_s_stb", v), s_stb, tbl[v].exp_sstb);
      check($sformatf("tbl%0d_m_ack", v), m_ack, tbl[v].exp_mack);
      tick();
    end

    // single master write/read with slave ACK on its second cycle
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001;
    m_adr[0 +: AW] = 32'h0010_0000; m_dat_o[0 +: DW] = 32'h1234_5678;
    m_adr[AW +: AW] = 32'hFFFF_0000; m_dat_o[DW +: DW] = 32'h0BAD_0BAD;
    #1;
    check("single_latency", grant, 0);
    tick(); #1;
    check("single_grant", grant, 3'b001);
    check("single_state", dbg_state, 1);
    check("single_s_adr", s_adr, 32'h0010_0000);
    check("single_s_we", s_we, 1);
    check("single_s_dat_o", s_dat_o, 32'h1234_5678);
    check("single_no_ack_yet", m_ack, 0);
    tick();
    s_ack = 1'b1; s_dat_i = 32'hDEAD_BEEF; m_we = 3'b000;
    #1;
    check("single_ack", m_ack, 3'b001);
    check("single_rdata", m_dat_i, 32'hDEAD_BEEF);
    check("single_s_we_read", s_we, 0);
    tick();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    #1;
    check("single_ack_drop", m_ack, 0);
    check("single_hold_until_edge", grant, 3'b001);
    tick(); #1;
    check("single_release", grant, 0);
    check("single_idle_s_adr", s_adr, 0);

    // burst hold: master 0 keeps CYC through 4 beats while master 1 waits
    m_cyc = 3'b001; m_stb = 3'b001;
    tick(); #1;
    check("burst_grant", grant, 3'b001);
    m_cyc = 3'b011; m_stb = 3'b011; s_ack = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_dat_i = 32'hB000_0000 + b;
      #1;
      check($sformatf("burst%0d_grant", b), grant, 3'b001);
      check($sformatf("burst%0d_m_ack", b), m_ack, 3'b001);
      tick();
    end
    m_cyc = 3'b010; m_stb = 3'b010; s_ack = 1'b0;
    #1;
    check("handover_k", grant, 3'b001);
    tick(); #1;
    check("handover_k1", grant, 0);
    tick(); #1;
    check("handover_k2", grant, 3'b010);
    check("handover_s_cyc", s_cyc, 1);
    m_cyc = '0; m_stb = '0;
    tick(); tick();

    // simultaneous requests alternate 0,1,0,1
    do_reset();
    m_cyc = 3'b011; m_stb = 3'b011;
    tick();
    for (int r = 0; r < 4; r++) begin
      #1;
      check($sformatf("alt%0d_grant", r), grant, (r % 2 == 0) ? 3'b001 : 3'b010);
      o = r % 2;
      m_cyc[o] = 1'b0;
      tick(); #1;
      check($sformatf("alt%0d_gap", r), grant, 0);
      m_cyc[o] = 1'b1;
      tick();
    end

    // asynchronous reset while master 1 owns the bus
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    tick(); #1;
    check("rstbusy_owner1", grant, 3'b010);
    m_cyc = 3'b011; m_stb = 3'b011; s_ack = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rstbusy_grant", grant, 0);
    check("rstbusy_s_cyc", s_cyc, 0);
    check("rstbusy_s_stb", s_stb, 0);
    check("rstbusy_m_ack", m_ack, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstbusy_after_release", grant, 0);
    tick(); #1;
    check("rstbusy_master0_first", grant, 3'b001);

    // randomized traffic against the reference model
    do_reset();
    own = -1; lst = N - 1; req = '0; since_ack = 0;
    exp_q.delete();
    exp_q.push_back('0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end else if (own == i && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b0;
        end
        m_adr[i*AW +: AW]   = $urandom;
        m_dat_o[i*DW +: DW] = $urandom;
      end
      m_cyc = req;
      m_stb = req & 3'($urandom_range(0, 7));
      m_we  = 3'($urandom_range(0, 7));
      s_ack = (since_ack >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      since_ack = s_ack ? 0 : since_ack + 1;
      s_dat_i = $urandom;
      #1;
      eg = exp_q.pop_front();
      check("rnd_grant", grant, eg);
      check("rnd_s_cyc", s_cyc, (own >= 0) ? req[own] : 1'b0);
      check("rnd_s_adr", s_adr, (own >= 0) ? m_adr[own*AW +: AW] : '0);
      check("rnd_s_dat_o", s_dat_o, (own >= 0) ? m_dat_o[own*DW +: DW] : '0);
      check("rnd_m_ack", m_ack, (own >= 0 && s_ack) ? (1 << own) : 0);
      check("rnd_m_dat_i", m_dat_i, (own >= 0) ? s_dat_i : '0);
      if (own < 0) begin
        for (int k = 1; k <= N; k++) begin
          if (own < 0 && req[(lst + k) % N]) own = (lst + k) % N;
        end
      end else if (!req[own]) begin
        lst = own;
        own = -1;
      end
      exp_q.push_back((own < 0) ? 3'b000 : 3'(1 << own));
      tick();
    end

    // stalled slave
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001; s_dat_i = 32'hA5A5_A5A5;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int j = 0; j < 10; j++) begin
      #1;
      if (j < 8) begin
        check($sformatf("to%0d_m_ack", j), m_ack, 0);
        check($sformatf("to%0d_s_stb", j), s_stb, 1);
      end else if (j == 8) begin
        check("to_fire_m_ack", m_ack, 3'b001);
        check("to_fire_m_dat_i", m_dat_i, 0);
        check("to_fire_s_stb", s_stb, 0);
      end else begin
        check("to_after_m_ack", m_ack, 0);
      end
      check($sformatf("to%0d_flag", j), timeout_flag, (j == 9) ? 1 : 0);
      check($sformatf("to%0d_grant", j), grant, 3'b001);
      tick();
    end
    m_cyc = '0; m_stb = '0;
    tick(); tick(); #1;
    check("to_flag_sticky", timeout_flag, 1);
    check("to_grant_released", grant, 0);
    do_reset(); #1;
    check("to_flag_cleared", timeout_flag, 0);
`else
    for (int j = 0; j < 30; j++) begin
      #1;
      check($sformatf("stall%0d_m_ack", j), m_ack, 0);
      check($sformatf("stall%0d_grant", j), grant, 3'b001);
      check($sformatf("stall%0d_flag", j), timeout_flag, 0);
      tick();
    end
    m_cyc = '0; m_stb = '0;
    tick(); tick();
`endif

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
